// File: rtl/rr_select_encoder4_pkg.sv
// rtl/rr_select_encoder4_pkg.sv - shared types, constants and search helpers for the round-robin select encoder
package rr_select_encoder4_pkg;

    localparam int NSRC = 4;
    localparam int SELW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    // First set bit of vec, scanning upward from start and wrapping around.
    function automatic logic [SELW-1:0] first_one_from(input logic [NSRC-1:0] vec,
                                                       input logic [SELW-1:0] start);
        logic [SELW-1:0] idx;
        logic [SELW-1:0] res;
        logic            found;
        res   = start;
        found = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            idx = start + SELW'(k);
            if (!found && vec[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [NSRC-1:0] sel_decode(input logic [SELW-1:0] sel);
        return NSRC'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_select_encoder4_if.sv
// rtl/rr_select_encoder4_if.sv - request/release inputs and decoder-side select outputs of the encoder
interface rr_select_encoder4_if;
    import rr_select_encoder4_pkg::*;

    logic [NSRC-1:0] req;
    logic            done;
    logic            s1;
    logic            s0;
    logic            en;
    logic [NSRC-1:0] gnt;
    logic            timeout;

    modport master (output req, done, input s1, s0, en, gnt, timeout);
    modport slave  (input req, done, output s1, s0, en, gnt, timeout);
endinterface

// File: rtl/rr_select_encoder4_pick4.sv
// rtl/rr_select_encoder4_pick4.sv - combinational round-robin picker starting after the last granted source
module rr_pick4
    import rr_select_encoder4_pkg::*;
(
    input  logic [NSRC-1:0] req_i,
    input  logic [SELW-1:0] last_i,
    output logic [SELW-1:0] win_o,
    output logic            any_o
);

    assign any_o = |req_i;
    assign win_o = first_one_from(req_i, last_i + SELW'(1));

endmodule

// File: rtl/rr_select_encoder4.sv
// rtl/rr_select_encoder4.sv - round-robin select/enable generator for a 4:1 tri-state bus mux with turnaround
module rr_select_encoder4
    import rr_select_encoder4_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_select_encoder4_if.slave  bus
);

    localparam int HCW = (HOLD_MAX > 0) ? (($clog2(HOLD_MAX + 1) > 0) ? $clog2(HOLD_MAX + 1) : 1) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    state_t          state_q;
    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] last_q;
    logic [HCW-1:0]  cnt_q;
    logic            en_q;
    logic [NSRC-1:0] gnt_q;
    logic            timeout_q;

    logic [SELW-1:0] win;
    logic            any_req;
    logic            owner_req;
    logic            hit_limit;
    logic            release_now;

    rr_pick4 u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .win_o  (win),
        .any_o  (any_req)
    );

    assign owner_req   = bus.req[sel_q];
    assign hit_limit   = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);
    assign release_now = bus.done || !owner_req || hit_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            last_q    <= SELW'(NSRC - 1);
            cnt_q     <= '0;
            en_q      <= 1'b0;
            gnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    en_q  <= 1'b0;
                    gnt_q <= '0;
                    if (any_req) begin
                        sel_q   <= win;
                        last_q  <= win;
                        en_q    <= 1'b1;
                        gnt_q   <= sel_decode(win);
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // sel_q is left alone so the decoder inputs stay quiet through the dead cycle
                        en_q      <= 1'b0;
                        gnt_q     <= '0;
                        timeout_q <= hit_limit && !bus.done && owner_req;
                        state_q   <= TURN;
                    end else begin
                        cnt_q <= cnt_q + HCW'(1);
                    end
                end
                TURN: begin
                    state_q <= IDLE;
                end
                default: begin
                    en_q    <= 1'b0;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.s1      = sel_q[1];
    assign bus.s0      = sel_q[0];
    assign bus.en      = en_q;
    assign bus.gnt     = gnt_q;
    assign bus.timeout = timeout_q;

endmodule
